// File: rtl/silu_backward.sv
// Backward SiLU: dx = g * (s + x*s') using the piecewise-quadratic sigmoid model.
// Four registered stages that advance together whenever the output is free or being taken.
module silu_backward #(
    parameter int IL = 4,
    parameter int FL = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IL+FL-1:0] x,
    input  logic [IL+FL-1:0] g,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IL+FL-1:0] dx
);
    localparam int W  = IL + FL;
    localparam int WI = W + 2;
    localparam int WP = 2 * WI;

    localparam logic signed [WI-1:0] ZERO_C = {WI{1'b0}};
    localparam logic signed [WI-1:0] ONE_C  = {{(WI-FL-1){1'b0}}, 1'b1, {FL{1'b0}}};
    localparam logic signed [WI-1:0] FOUR_C = {{(WI-FL-3){1'b0}}, 3'b100, {FL{1'b0}}};
    localparam logic signed [WP-1:0] MAX_C  = {{(WP-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [WP-1:0] MIN_C  = {{(WP-W+1){1'b1}}, {(W-1){1'b0}}};

    function automatic logic [W-1:0] sat_w(input logic signed [WP-1:0] v);
        logic [W-1:0] r;
        if (v > MAX_C) begin
            r = MAX_C[W-1:0];
        end else if (v < MIN_C) begin
            r = MIN_C[W-1:0];
        end else begin
            r = v[W-1:0];
        end
        return r;
    endfunction

    logic                 en_s;
    logic signed [WI-1:0] x_ext_s, a_s, t_raw_s, t_s;
    logic signed [WI-1:0] t2_s, sp_s, s_s, xs_s, d_s;
    logic signed [WP-1:0] gd_s;
    logic [W-1:0]         dx_s;

    logic                 v1_r, v2_r, v3_r, out_valid_r;
    logic signed [WI-1:0] x1_r, t1_r, x2_r, t2_r, sp2_r, s3_r, xs3_r;
    logic signed [W-1:0]  g1_r, g2_r, g3_r;
    logic                 neg1_r, neg2_r;
    logic [W-1:0]         dx_r;

    assign en_s      = !out_valid_r || out_ready;
    assign in_ready  = en_s;
    assign out_valid = out_valid_r;
    assign dx        = dx_r;

    // Stage-1 math: |x| and the clamped linear ramp t.
    always_comb begin
        x_ext_s = WI'($signed(x));
        if (x[W-1]) begin
            a_s = -x_ext_s;
        end else begin
            a_s = x_ext_s;
        end
        t_raw_s = ONE_C - (a_s >>> 2);
        // Most-negative x widens to +8.0 here, so it lands in the clamp like any |x| >= 4.
        if (t_raw_s[WI-1] || (a_s >= FOUR_C)) begin
            t_s = ZERO_C;
        end else begin
            t_s = t_raw_s;
        end
    end

    // Stages 2-4 math: t squared, slope, sigmoid, derivative and saturated product.
    always_comb begin
        t2_s = WI'((WP'(t1_r) * WP'(t1_r)) >>> FL);
        sp_s = t1_r >>> 2;
        if (neg2_r) begin
            s_s = t2_r >>> 1;
        end else begin
            s_s = ONE_C - (t2_r >>> 1);
        end
        xs_s = WI'((WP'(x2_r) * WP'(sp2_r)) >>> FL);
        d_s  = s3_r + xs3_r;
        gd_s = (WP'(g3_r) * WP'(d_s)) >>> FL;
        dx_s = sat_w(gd_s);
    end

    // Pipeline registers: everything shifts on en_s and freezes otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_r        <= 1'b0;
            v2_r        <= 1'b0;
            v3_r        <= 1'b0;
            out_valid_r <= 1'b0;
            x1_r        <= ZERO_C;
            t1_r        <= ZERO_C;
            g1_r        <= {W{1'b0}};
            neg1_r      <= 1'b0;
            x2_r        <= ZERO_C;
            t2_r        <= ZERO_C;
            sp2_r       <= ZERO_C;
            g2_r        <= {W{1'b0}};
            neg2_r      <= 1'b0;
            s3_r        <= ZERO_C;
            xs3_r       <= ZERO_C;
            g3_r        <= {W{1'b0}};
            dx_r        <= {W{1'b0}};
        end else if (en_s) begin
            v1_r        <= in_valid;
            x1_r        <= x_ext_s;
            t1_r        <= t_s;
            g1_r        <= $signed(g);
            neg1_r      <= x[W-1];
            v2_r        <= v1_r;
            x2_r        <= x1_r;
            t2_r        <= t2_s;
            sp2_r       <= sp_s;
            g2_r        <= g1_r;
            neg2_r      <= neg1_r;
            v3_r        <= v2_r;
            s3_r        <= s_s;
            xs3_r       <= xs_s;
            g3_r        <= g2_r;
            out_valid_r <= v3_r;
            dx_r        <= dx_s;
        end
    end

endmodule

// File: tb/tb_silu_backward.sv
// Self-checking bench for silu_backward: directed spec values plus randomized traffic
// scored against an arithmetic reference of the gradient formula.
module tb_silu_backward;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] x;
    logic [19:0] g;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] dx;

    int          checks = 0;
    int          errors = 0;
    int          n_out  = 0;
    logic [19:0] sb[$];
    logic        stalled_prev = 1'b0;
    logic [19:0] held_dx = 20'h00000;

    silu_backward #(.IL(4), .FL(16)) dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .g(g), .out_valid(out_valid), .out_ready(out_ready), .dx(dx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dx = g * (s + x * s') with the quadratic sigmoid, floor shifts and saturation
    function automatic logic [19:0] ref_dx(input logic [19:0] xv, input logic [19:0] gv);
        longint xi, gi, a, t, t2, sp, s, xs, d, p;
        xi = longint'($signed(xv));
        gi = longint'($signed(gv));
        a  = (xi < 0) ? -xi : xi;
        t  = 65536 - (a >>> 2);
        if (t < 0 || a >= 262144) t = 0;
        t2 = (t * t) >>> 16;
        sp = t >>> 2;
        s  = (xi >= 0) ? (65536 - (t2 >>> 1)) : (t2 >>> 1);
        xs = (xi * sp) >>> 16;
        d  = s + xs;
        p  = (gi * d) >>> 16;
        if (p > 524287) p = 524287;
        if (p < -524288) p = -524288;
        return 20'(p);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated pair: exact latency and value.
    task automatic latency_one(input logic [19:0] xv, input logic [19:0] gv,
                               input logic [19:0] expv, input string tag);
        step();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x = xv;
        g = gv;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_early"}, 32'(out_valid), 32'd0);
            step();
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(dx), 32'(expv));
    endtask

    // Scoreboard monitor, sampled mid-cycle when inputs are settled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    chk("dx_model", 32'(dx), 32'(sb.pop_front()));
                    n_out++;
                end
            end
            if (out_valid && !out_ready) begin
                chk("in_ready_stall", 32'(in_ready), 32'd0);
                if (stalled_prev) chk("dx_hold", 32'(dx), 32'(held_dx));
                held_dx      = dx;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (in_valid && in_ready) sb.push_back(ref_dx(x, g));
        end else begin
            stalled_prev = 1'b0;
        end
    end

    initial begin
        logic [19:0] tx[7];
        logic [19:0] tg[7];
        logic [19:0] te[7];
        logic        acc;
        logic        pat_bit;
        int          tries;
        int          n0;
        logic [19:0] rx, rg;

        tx = '{20'h00000, 20'h20000, 20'hE0000, 20'h50000, 20'h80000, 20'h20000, 20'h20000};
        tg = '{20'h10000, 20'h10000, 20'h10000, 20'hD0000, 20'h10000, 20'h7F000, 20'h81000};
        te = '{20'h08000, 20'h12000, 20'hFE000, 20'hD0000, 20'h00000, 20'h7FFFF, 20'h80000};

        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x = 20'h00000;
        g = 20'h00000;
        #2 rst_n = 1'b0;
        repeat (3) step();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_dx", 32'(dx), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) latency_one(tx[i], tg[i], te[i], $sformatf("basic%0d", i));

        // Back-to-back stream with a 5-cycle output stall in the middle.
        step();
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    x = 20'($urandom);
                    g = 20'($urandom);
                    if (i % 2 == 0) x = {x[19], 2'b00, x[16:0]};
                    in_valid = 1'b1;
                    tries = 0;
                    acc = 1'b0;
                    do begin
                        @(negedge clk);
                        acc = in_ready;
                        step();
                        tries++;
                    end while (!acc && tries < 50);
                    if (!acc) chk("bp_accept_timeout", 32'(acc), 32'd1);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) step();
                out_ready = 1'b0;
                repeat (5) step();
                out_ready = 1'b1;
            end
        join
        for (int c = 0; c < 50 && sb.size() != 0; c++) step();
        chk("bp_drain", 32'(sb.size()), 32'd0);
        chk("bp_count", 32'(n_out - n0), 32'd8);

        // Mode 0: alternating bubbles; mode 1: continuous stream of 10.
        for (int mode = 0; mode < 2; mode++) begin
            for (int j = 0; j < 20; j++) begin
                step();
                if (j >= 4) begin
                    if (mode == 0) pat_bit = (j - 4 < 12) && ((j - 4) % 2 == 0);
                    else           pat_bit = (j - 4 < 10);
                end else begin
                    pat_bit = 1'b0;
                end
                chk($sformatf("valid_pattern_m%0d_c%0d", mode, j), 32'(out_valid), 32'(pat_bit));
                x = 20'($urandom);
                g = 20'($urandom);
                if (mode == 0) in_valid = (j < 12) && (j % 2 == 0);
                else           in_valid = (j < 10);
            end
        end
        in_valid = 1'b0;

        // Asynchronous reset with three pairs in flight.
        step();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = 20'($urandom);
            g = 20'($urandom);
            step();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 32'(out_valid), 32'd0);
        chk("async_reset_dx", 32'(dx), 32'd0);
        chk("async_reset_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        step();
        step();
        #2 rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            chk("post_reset_idle", 32'(out_valid), 32'd0);
        end
        rx = 20'($urandom);
        rg = 20'($urandom);
        rx = {rx[19], 2'b00, rx[16:0]};
        latency_one(rx, rg, ref_dx(rx, rg), "post_reset");

        for (int c = 0; c < 20 && sb.size() != 0; c++) step();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
